shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle 32-bit logical-right-shift / rotate-right unit for the ALU shift path.
//  It sits directly upstream of the barrel-shift stages and owns their control. It captures
//  an operand and a 5-bit amount with a start/busy/done handshake, then resolves the amount
//  one binary stage per clock, MSB stage first: 16, 8, 4, 2, then 1.
//  Each stage follows the same rule as the 4-bit stage: y[i] = x[i+2^k].
//  The vacated top bits take 0 for a shift, or x[2^k-1:0] for a rotate.
// PARAMETERS
//  WIDTH      32  data width; must be a power of 2; localparam AW = $clog2(WIDTH)
//  FAST_ZERO  1   1: an amount of 0 bypasses RUN and goes straight to DONE; 0: always runs all AW stages
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      request; sampled only in IDLE
//  shift_rot  in   1      0 = logical right shift (zero fill), 1 = rotate right
//  amt        in   AW     shift amount, 0..WIDTH-1
//  din        in   WIDTH  operand
//  busy       out  1      high whenever state != IDLE
//  done       out  1      one-cycle pulse while in DONE
//  dout       out  WIDTH  result register
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; work, amt_q, mode_q, cnt = 0
//   - dout=0, busy=0, done=0
//   - An operation in flight is discarded; there is no done pulse for it.
//  State machine: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - On an edge with start=1: work<=din, amt_q<=amt, mode_q<=shift_rot, cnt<=AW-1.
//   - Next state is RUN, or DONE if FAST_ZERO=1 and amt==0.
//  RUN, each edge:
//   - If amt_q[cnt]=1, work <= stage(work, 2^cnt, mode_q); otherwise work holds.
//   - stage: low bits take work[i+2^cnt]; the top 2^cnt bits take 0 (shift) or work[2^cnt-1:0] (rotate).
//   - If cnt==0, go to DONE and load dout with the final stage value (combinational next-work).
//     Otherwise cnt<=cnt-1.
//  DONE:
//   - done=1 for exactly one cycle, then IDLE.
//   - On FAST_ZERO entry, dout<=din, captured at the start edge.
//  dout changes only on entry to DONE and holds until the next completion or reset.
//   - Intermediate work values never appear on dout.
//  Latency, counting the cycle in which start is sampled as cycle 0:
//   - done is high in cycle AW+1 (6 for WIDTH=32).
//   - With FAST_ZERO=1 and amt=0, done is high in cycle 1.
//  Throughput: a new start is accepted only in IDLE. Back-to-back operations therefore take AW+2 cycles each.
//  Boundary conditions:
//   - start while busy (RUN or DONE) is ignored. The in-flight operands are unaffected.
//   - din, amt and shift_rot may change freely after the start edge; only the captured copies are used.
//   - amt=WIDTH-1 shift leaves only the original bit WIDTH-1, at bit 0.
//   - amt=WIDTH-1 rotate equals a rotate-left by 1.
//   - rst asserted mid-RUN forces IDLE immediately, with dout=0 and done=0.
//     After rst is released, the first start behaves exactly as it does from power-up.
// TESTING
//  1. din=32'h8000_0001, amt=4, shift_rot=0 -> dout=32'h0800_0000, done in cycle 6, busy high in cycles 1-6.
//  2. Same operands with shift_rot=1 -> dout=32'h1800_0000.
//  3. Rotate din=32'h0000_0001 by amt=31 -> 32'h0000_0002. Shift din=32'hFFFF_FFFF by amt=31 -> 32'h0000_0001.
//  4. amt=0, din=32'hDEAD_BEEF: FAST_ZERO=1 -> done in cycle 1, dout=32'hDEAD_BEEF.
//     FAST_ZERO=0 -> same dout, done in cycle 6.
//  5. Hold start=1 with new din during RUN -> ignored; first result correct.
//     The next operation starts only after IDLE; exactly one done per accepted start.
//  6. Assert rst in cycle 3 of an operation -> busy=0, done=0, dout=0 at once; no done follows.
//     After release, rotate 32'h0000_00F0 by 8 -> 32'hF000_0000.
//     Random sweep vs. a >>/rotate reference model for both modes.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle logical-right-shift / rotate-right sequencer. The amount is resolved one
// binary stage per clock, largest stage first, with a start/busy/done handshake.
module shift_sequencer #(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     shift_rot,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [WIDTH-1:0]         din,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] work, work_next, stage_shr, stage_rol, stage_val;
  logic [AW-1:0]    amt_q;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  int unsigned      stage_dist;

  // One barrel stage of distance 2^cnt; rotate refills the top bits from the low bits.
  always_comb begin
    stage_dist = 32'd1 << cnt;
    stage_shr  = work >> stage_dist;
    stage_rol  = work << (WIDTH - stage_dist);
    stage_val  = mode_q ? (stage_shr | stage_rol) : stage_shr;
    work_next  = amt_q[cnt] ? stage_val : work;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (FAST_ZERO && amt == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      amt_q  <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= din;
            amt_q  <= amt;
            mode_q <= shift_rot;
            cnt    <= CW'(AW - 1);
            if (FAST_ZERO && amt == '0) dout <= din;
          end
        end
        RUN: begin
          work <= work_next;
          if (cnt == '0) dout <= work_next;
          else           cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
